uart_rx: RTL

//  UART receiver for the uart subsystem; counterpart of the team's UART transmitter.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_baud_tick.sv | 33 +++
 rtl/uart_rx.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART types and constants: receiver state encoding, oversampling
// ratio, data width and the oversampling tick divisor helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_rx_state_t;

  localparam int OSR       = 16;
  localparam int DATA_BITS = 8;

  // Clocks per oversampling tick: floor(clk / (baud * osr)), never below 1.
  function automatic int calc_osr_div(input int clk_freq, input int baud, input int osr = OSR);
    int div;
    div = clk_freq / (baud * osr);
    return (div < 1) ? 1 : div;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversampling tick generator: one-clock strobe every OSR_DIV clocks.
// Free-running down-counter, cleared only by reset; shared with the transmitter.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 1_843_200,
  parameter int BAUD_RATE = 9600,
  parameter int OSR       = uart_pkg::OSR
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int OSR_DIV = calc_osr_div(CLK_FREQ, BAUD_RATE, OSR);
  localparam int CW      = (OSR_DIV > 1) ? $clog2(OSR_DIV) : 1;

  logic [CW-1:0] r_cnt;

  // Count down to zero, strobe, reload.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (r_cnt == '0) begin
      r_cnt <= CW'(OSR_DIV - 1);
    end else begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign tick = (r_cnt == '0);

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 16x oversampled, LSB first, one-entry valid/ready holding register.
// Optional parity bit enabled by defining UART_RX_PARITY_EN (8E1/8O1, else 8N1).
//
//   state  | meaning
//   IDLE   | line idle, watching for a low level on each tick
//   START  | start bit seen, confirm at mid-bit (8 ticks)
//   DATA   | sample 8 data bits every 16 ticks
//   PARITY | sample parity bit (only with UART_RX_PARITY_EN)
//   STOP   | sample stop bit, judge frame, back to IDLE
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 1_843_200,
  parameter int BAUD_RATE  = 9600,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 busy,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun
);

  logic                 w_tick;
  logic                 r_rx_meta;
  logic                 r_rx_sync;
  uart_rx_state_t       r_state;
  uart_rx_state_t       w_state_nxt;
  logic [3:0]           r_tick_cnt;
  logic [3:0]           w_tick_cnt_nxt;
  logic [2:0]           r_bit_cnt;
  logic [2:0]           w_bit_cnt_nxt;
  logic                 w_shift;
  logic                 w_par_smp;
  logic                 w_stop_smp;
  logic                 w_par_bad;
  logic                 w_good;
  logic                 w_accept;
  logic [DATA_BITS-1:0] r_shreg;
  logic [DATA_BITS-1:0] r_rx_data;
  logic                 r_rx_valid;
  logic                 r_frame_err;
  logic                 r_parity_err;
  logic                 r_overrun;

  uart_baud_tick #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD_RATE(BAUD_RATE),
    .OSR      (OSR)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .tick(w_tick)
  );

  // Two-flop synchronizer on the async line; idles high.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_sync <= r_rx_meta;
    end
  end

  // FSM state, tick-within-bit and bit counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_tick_cnt <= '0;
      r_bit_cnt  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_tick_cnt <= w_tick_cnt_nxt;
      r_bit_cnt  <= w_bit_cnt_nxt;
    end
  end

  // Next-state logic and sample strobes; the 4-bit tick count wraps every bit.
  always_comb begin
    w_state_nxt    = r_state;
    w_tick_cnt_nxt = r_tick_cnt;
    w_bit_cnt_nxt  = r_bit_cnt;
    w_shift        = 1'b0;
    w_par_smp      = 1'b0;
    w_stop_smp     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_tick && !r_rx_sync) begin
          w_state_nxt    = START;
          w_tick_cnt_nxt = '0;
        end
      end
      START: begin
        if (w_tick) begin
          if (r_tick_cnt == 4'd7) begin
            w_tick_cnt_nxt = '0;
            w_bit_cnt_nxt  = '0;
            w_state_nxt    = r_rx_sync ? IDLE : DATA;
          end else begin
            w_tick_cnt_nxt = r_tick_cnt + 1'b1;
          end
        end
      end
      DATA: begin
        if (w_tick) begin
          w_tick_cnt_nxt = r_tick_cnt + 1'b1;
          if (r_tick_cnt == 4'd15) begin
            w_shift = 1'b1;
            if (r_bit_cnt == 3'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
              w_state_nxt = PARITY;
`else
              w_state_nxt = STOP;
`endif
            end else begin
              w_bit_cnt_nxt = r_bit_cnt + 1'b1;
            end
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (w_tick) begin
          w_tick_cnt_nxt = r_tick_cnt + 1'b1;
          if (r_tick_cnt == 4'd15) begin
            w_par_smp   = 1'b1;
            w_state_nxt = STOP;
          end
        end
      end
`endif
      STOP: begin
        if (w_tick) begin
          w_tick_cnt_nxt = r_tick_cnt + 1'b1;
          if (r_tick_cnt == 4'd15) begin
            w_stop_smp  = 1'b1;
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

`ifdef UART_RX_PARITY_EN
  logic r_par_bit;

  // Capture the received parity bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_par_bit <= 1'b0;
    end else if (w_par_smp) begin
      r_par_bit <= r_rx_sync;
    end
  end

  assign w_par_bad = (r_par_bit != (^r_shreg ^ PARITY_ODD));
`else
  // PARITY_ODD has no effect when the parity bit is absent.
  assign w_par_bad = 1'b0 & PARITY_ODD & w_par_smp;
`endif

  assign w_good   = w_stop_smp && r_rx_sync && !w_par_bad;
  assign w_accept = r_rx_valid && rx_ready;

  // Shift register, holding register and one-clock status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shreg      <= '0;
      r_rx_data    <= '0;
      r_rx_valid   <= 1'b0;
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      if (w_shift) begin
        r_shreg <= {r_rx_sync, r_shreg[DATA_BITS-1:1]};
      end
      r_frame_err  <= w_stop_smp && !r_rx_sync;
      r_parity_err <= w_stop_smp && w_par_bad;
      r_overrun    <= w_good && r_rx_valid && !w_accept;
      if (w_good && (!r_rx_valid || w_accept)) begin
        r_rx_data  <= r_shreg;
        r_rx_valid <= 1'b1;
      end else if (w_accept) begin
        r_rx_valid <= 1'b0;
      end
    end
  end

  assign rx_data    = r_rx_data;
  assign rx_valid   = r_rx_valid;
  assign busy       = (r_state == DATA) || (r_state == PARITY) || (r_state == STOP);
  assign frame_err  = r_frame_err;
  assign parity_err = r_parity_err;
  assign overrun    = r_overrun;

endmodule
